// File: rtl/scan_pair_array_if.sv
// scan_pair_array_if: functional, scan and test-controller signals of one scan_pair_array
//   master: drives a, scan_en, scan_in, test_start; observes k, scan_out, busy, done
//   slave : the array side of the same bundle
interface scan_pair_array_if #(
  parameter int PAIRS  = 2,
  parameter int CHAINS = 2
);
  logic [PAIRS-1:0]  a;
  logic              scan_en;
  logic [CHAINS-1:0] scan_in;
  logic              test_start;
  logic [PAIRS-1:0]  k;
  logic [CHAINS-1:0] scan_out;
  logic              busy;
  logic              done;
  modport master (output a, scan_en, scan_in, test_start, input k, scan_out, busy, done);
  modport slave  (input a, scan_en, scan_in, test_start, output k, scan_out, busy, done);
endinterface

// File: rtl/scan_pair_array.sv
// scan_pair_array: array of two-flop cells on scan chains with an automatic load/capture/unload controller
//   clk   : clock, all state updates on posedge
//   reset : synchronous active-high reset
//   bus   : a/k functional path, scan_en/scan_in/scan_out serial access,
//           test_start/busy/done automatic test sequence control
module scan_pair_array #(
  parameter int PAIRS  = 2,
  parameter int CHAINS = 2
) (
  input logic            clk,
  input logic            reset,
  scan_pair_array_if.slave bus
);
  localparam int WIDTH = 2 * PAIRS;
  localparam int L     = WIDTH / CHAINS;
  localparam int CW    = $clog2(L) + 1;
  if (WIDTH % CHAINS != 0) begin : g_bad_chains
    $error("scan_pair_array: 2*PAIRS must be a multiple of CHAINS");
  end
  typedef enum logic [1:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic done_n, sh_en, last;
  logic [WIDTH-1:0] s, s_func, s_shift;
  logic [PAIRS-1:0] d;
  // the controller owns the shift enable while a sequence is running
  assign sh_en = state == IDLE ? bus.scan_en : state != CAPTURE;
  assign last  = cnt == CW'(L - 1);
  assign bus.busy = state != IDLE;
  assign bus.k    = sh_en ? '0 : d & ~bus.a;
  for (genvar p = 0; p < PAIRS; p++) begin : g_cell
    assign d[p]           = s[2*p] | s[2*p+1];
    assign s_func[2*p]    = bus.a[p] & d[p];
    assign s_func[2*p+1]  = ~d[p];
  end
  for (genvar c = 0; c < CHAINS; c++) begin : g_chain
    assign bus.scan_out[c] = s[c*L+L-1];
    assign s_shift[c*L]    = bus.scan_in[c];
    for (genvar j = 1; j < L; j++) begin : g_link
      assign s_shift[c*L+j] = s[c*L+j-1];
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    case (state)
      IDLE:      if (bus.test_start) begin
                   state_n = SHIFT_IN;
                   cnt_n   = '0;
                 end
      SHIFT_IN:  begin
                   state_n = last ? CAPTURE : SHIFT_IN;
                   cnt_n   = last ? '0 : cnt + CW'(1);
                 end
      CAPTURE:   state_n = SHIFT_OUT;
      SHIFT_OUT: begin
                   state_n = last ? IDLE : SHIFT_OUT;
                   cnt_n   = last ? '0 : cnt + CW'(1);
                   done_n  = last;
                 end
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.done <= 1'b0;
      s        <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bus.done <= done_n;
      s        <= sh_en ? s_shift : s_func;
    end
  end
endmodule

// File: tb/tb_scan_pair_array.sv
// tb_scan_pair_array: three array configurations driven in lockstep and checked against a sequence-level model
module tb_scan_pair_array;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] a_w, si_w;
  logic se, ts;
  int checks = 0;
  int failures = 0;
  int np[3] = '{2, 3, 4};
  int nc[3] = '{2, 6, 1};
  logic [15:0] ms[3];
  int ctr[3];
  bit mdone[3];
  always #5 clk = ~clk;
  scan_pair_array_if #(.PAIRS(2), .CHAINS(2)) b0 ();
  scan_pair_array_if #(.PAIRS(3), .CHAINS(6)) b1 ();
  scan_pair_array_if #(.PAIRS(4), .CHAINS(1)) b2 ();
  scan_pair_array #(.PAIRS(2), .CHAINS(2)) d0 (.clk(clk), .reset(reset), .bus(b0));
  scan_pair_array #(.PAIRS(3), .CHAINS(6)) d1 (.clk(clk), .reset(reset), .bus(b1));
  scan_pair_array #(.PAIRS(4), .CHAINS(1)) d2 (.clk(clk), .reset(reset), .bus(b2));
  assign b0.a = a_w[1:0];
  assign b0.scan_in = si_w[1:0];
  assign b0.scan_en = se;
  assign b0.test_start = ts;
  assign b1.a = a_w[2:0];
  assign b1.scan_in = si_w[5:0];
  assign b1.scan_en = se;
  assign b1.test_start = ts;
  assign b2.a = a_w[3:0];
  assign b2.scan_in = si_w[0:0];
  assign b2.scan_en = se;
  assign b2.test_start = ts;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int len(int i);
    return 2 * np[i] / nc[i];
  endfunction
  // a sequence occupies positions 1..L (load), L+1 (capture), L+2..2L+1 (unload)
  function automatic bit sh_of(int i);
    return ctr[i] == 0 ? se : ctr[i] != len(i) + 1;
  endfunction
  function automatic logic [15:0] func_next(logic [15:0] s, int p_n, logic [15:0] a);
    logic [15:0] r = '0;
    for (int p = 0; p < p_n; p++) begin
      bit dd = s[2*p] | s[2*p+1];
      r[2*p]   = a[p] & dd;
      r[2*p+1] = !dd;
    end
    return r;
  endfunction
  function automatic logic [15:0] shift_next(logic [15:0] s, int i, logic [15:0] si);
    logic [15:0] r = '0;
    int l = len(i);
    for (int c = 0; c < nc[i]; c++)
      for (int j = 0; j < l; j++)
        if (j == 0) r[c*l] = si[c];
        else r[c*l+j] = s[c*l+j-1];
    return r;
  endfunction
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int l = len(i);
      if (reset) begin
        ms[i] = '0;
        ctr[i] = 0;
        mdone[i] = 0;
      end else begin
        ms[i] = sh_of(i) ? shift_next(ms[i], i, si_w) : func_next(ms[i], np[i], a_w);
        mdone[i] = ctr[i] == 2 * l + 1;
        ctr[i] = ctr[i] == 0 ? (ts ? 1 : 0) : (ctr[i] == 2 * l + 1 ? 0 : ctr[i] + 1);
      end
    end
  endtask
  task automatic chk_cfg(input int i, input logic [15:0] k, input logic [15:0] so,
                         input logic busy, input logic done, input logic [15:0] s);
    logic [15:0] ek = '0;
    logic [15:0] eso = '0;
    int l = len(i);
    for (int p = 0; p < np[i]; p++)
      ek[p] = !sh_of(i) && (ms[i][2*p] | ms[i][2*p+1]) && !a_w[p];
    for (int c = 0; c < nc[i]; c++) eso[c] = ms[i][c*l+l-1];
    chk($sformatf("c%0d_s", i), 32'(s), 32'(ms[i]));
    chk($sformatf("c%0d_k", i), 32'(k), 32'(ek));
    chk($sformatf("c%0d_scan_out", i), 32'(so), 32'(eso));
    chk($sformatf("c%0d_busy", i), 32'(busy), 32'(ctr[i] != 0));
    chk($sformatf("c%0d_done", i), 32'(done), 32'(mdone[i]));
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_cfg(0, 16'(b0.k), 16'(b0.scan_out), b0.busy, b0.done, 16'(d0.s));
    chk_cfg(1, 16'(b1.k), 16'(b1.scan_out), b1.busy, b1.done, 16'(d1.s));
    chk_cfg(2, 16'(b2.k), 16'(b2.scan_out), b2.busy, b2.done, 16'(d2.s));
  endtask
  initial begin
    int nb, dpos;
    reset = 1'b1;
    a_w = '0;
    si_w = '0;
    se = 1'b0;
    ts = 1'b0;
    cycle();
    cycle();
    chk("rst_k0", 32'(b0.k), 32'h0);
    chk("rst_so0", 32'(b0.scan_out), 32'h0);
    reset = 1'b0;
    a_w = 16'h3;
    cycle();
    chk("func_s1", 32'(d0.s), 32'hA);
    cycle();
    chk("func_s2", 32'(d0.s), 32'h5);
    chk("func_k_a11", 32'(b0.k), 32'h0);
    a_w = '0;
    #1;
    chk("func_k_a00", 32'(b0.k), 32'h3);
    @(negedge clk);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    se = 1'b1;
    si_w = 16'h3;
    cycle();
    chk("scan_k_1", 32'(b0.k), 32'h0);
    si_w = '0;
    cycle();
    chk("scan_s", 32'(d0.s), 32'hA);
    chk("scan_out", 32'(b0.scan_out), 32'h3);
    chk("scan_k_2", 32'(b0.k), 32'h0);
    se = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    ts = 1'b1;
    a_w = 16'h5;
    si_w = 16'h2D;
    nb = 0;
    dpos = 0;
    for (int t = 1; t <= 8; t++) begin
      cycle();
      ts = 1'b0;
      se = t[0];
      if (b0.busy) nb++;
      if (b0.done) dpos = t;
    end
    chk("seq_busy_cycles", 32'(nb), 32'd5);
    chk("seq_done_pos", 32'(dpos), 32'd6);
    for (int t = 0; t < 3000; t++) begin
      reset = $urandom_range(0, 59) == 0;
      ts = $urandom_range(0, 3) == 0;
      se = $urandom_range(0, 1) == 1;
      a_w = 16'($urandom);
      si_w = 16'($urandom);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scan_pair_array.md
SCAN_PAIR_ARRAY -- requirements
Module: scan_pair_array

Interface
REQ-001 Parameter PAIRS, default 2: number of two-flop functional cells; WIDTH = 2*PAIRS state flops.
REQ-002 Parameter CHAINS, default 2: number of scan chains; WIDTH % CHAINS == 0 SHALL hold, else elaboration error; chain length L = WIDTH/CHAINS.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high; sampled on posedge clk.
REQ-005 a  input  PAIRS  functional data input, one bit per cell.
REQ-006 scan_en  input  1  external scan shift enable, honoured only while controller idle.
REQ-007 scan_in  input  CHAINS  serial scan data, one bit per chain.
REQ-008 test_start  input  1  single-cycle request to run one automatic load/capture/unload sequence.
REQ-009 k  output  PAIRS  functional result, one bit per cell.
REQ-010 scan_out  output  CHAINS  serial scan data out, one bit per chain.
REQ-011 busy  output  1  high while controller is in SHIFT_IN, CAPTURE or SHIFT_OUT.
REQ-012 done  output  1  registered one-cycle completion pulse.

Function
REQ-013 State vector s[WIDTH-1:0]; cell p owns qB_p = s[2p], qC_p = s[2p+1].
REQ-014 Per cell: d_p = qB_p | qC_p; functional next state qB_p <= a[p] & d_p, qC_p <= ~d_p.
REQ-015 k[p] = d_p & ~a[p] (combinational), forced to 0 whenever effective shift enable (sh_en) is 1.
REQ-016 sh_en = scan_en when state is IDLE; 1 in SHIFT_IN and SHIFT_OUT; 0 in CAPTURE.
REQ-017 Chain c occupies s[c*L] .. s[c*L+L-1]; on shift: s[c*L] <= scan_in[c], s[c*L+j] <= s[c*L+j-1] for j = 1..L-1.
REQ-018 scan_out[c] = s[c*L+L-1], combinational from flops, valid in every mode.
REQ-019 When sh_en = 0, all flops take the functional next state (capture).
REQ-020 Controller FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT; shift counter width clog2(L)+1.
REQ-021 IDLE -> SHIFT_IN on posedge with test_start = 1; that same edge still uses scan_en as sh_en.
REQ-022 SHIFT_IN lasts exactly L cycles, then CAPTURE for exactly 1 cycle, then SHIFT_OUT for exactly L cycles, then IDLE.
REQ-023 busy = 1 exactly in the 2L+1 cycles following the test_start edge.
REQ-024 done = 1 for exactly one cycle: the first IDLE cycle after SHIFT_OUT; 0 otherwise.
REQ-025 test_start and scan_en while busy = 1 SHALL be ignored, with no queueing.
REQ-026 test_start held high SHALL start a new sequence on the done cycle (back-to-back allowed).
REQ-027 L = 1 is legal: SHIFT_IN and SHIFT_OUT each last one cycle.

Reset
REQ-028 reset = 1 at posedge: s = 0, FSM = IDLE, counter = 0, done = 0; this overrides test_start, scan_en and any in-flight sequence.
REQ-029 After reset: busy = 0, done = 0, scan_out = 0, k = 0 (since d_p = 0).

Verification (PAIRS=2, CHAINS=2, L=2 unless stated)
REQ-030 Reset, scan_en=0, a=2'b11, 2 clocks -> s=4'b1010 then 4'b0101; k=2'b00; then a=2'b00 -> k=2'b11.
REQ-031 Reset, scan_en=1, scan_in=2'b11 then 2'b00 -> s=4'b1010, scan_out=2'b11, k=2'b00 throughout.
REQ-032 Reset, pulse test_start -> busy high exactly 5 cycles, done high exactly on cycle 6, CAPTURE applies REQ-014 to the shifted-in pattern, scan_out streams the captured bits.
REQ-033 test_start and scan_en toggled during busy -> sequence length and s identical to the undisturbed run.
REQ-034 reset asserted in SHIFT_OUT -> next cycle s=0, busy=0, done=0, no done pulse later.
REQ-035 PAIRS=3, CHAINS=6 (L=1) and PAIRS=4, CHAINS=1 (L=8): REQ-022 timing holds, shift-in/out pattern round-trips bit-exact.
